// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor: diff = (num1 - num2 - bin) mod 2^WIDTH, computed
//   LSB-first, one bit per clock, through a single full-subtractor cell.
//   The borrow is carried between bits in a flop.
//
// Ports
//   clk     rising-edge clock
//   reset   asynchronous active-high reset; clears all state and outputs
//   start   request, sampled only while not busy (IDLE or FIN)
//   num1    minuend,    captured on an accepted start
//   num2    subtrahend, captured on an accepted start
//   bin     borrow-in to bit 0, captured on an accepted start
//   diff    registered result
//   borrow  registered borrow-out of the MSB (unsigned num1 < num2 + bin)
//   ovf     registered two's-complement overflow
//   busy    high while bits are being processed
//   done    one-cycle pulse when diff/borrow/ovf are updated
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic             w_d;
    logic             w_br_nxt;
    logic             w_last;
    logic [WIDTH-1:0] w_res;

    // Full-subtractor cell on the current LSBs of the shifting operands.
    assign w_d      = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_nxt = (~r_a[0] & r_b[0]) | (~r_a[0] & r_br) | (r_b[0] & r_br);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // Partial result enters from the MSB end, so after WIDTH shifts bit 0
    // sits at position 0. w_res is the complete word on the last bit's edge.
    // Only WIDTH-1 bits need storing: the newest bit comes straight from w_d.
    generate
        if (WIDTH > 1) begin : g_part
            logic [WIDTH-2:0] r_part;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    r_part <= '0;
                else if (r_state == RUN)
                    r_part <= w_res[WIDTH-1:1];
            end
            assign w_res = {w_d, r_part};
        end else begin : g_nopart
            assign w_res = w_d;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                // FIN also accepts start so back-to-back ops run every WIDTH+1 cycles.
                IDLE, FIN: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= num1;
                        r_b     <= num2;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_a_msb <= num1[WIDTH-1];
                        r_b_msb <= num2[WIDTH-1];
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff   <= w_res;
                        r_borrow <= w_br_nxt;
                        // Signed overflow: operand signs differ and the result
                        // sign differs from the minuend's.
                        r_ovf    <= (r_a_msb ^ r_b_msb) & (w_res[WIDTH-1] ^ r_a_msb);
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= FIN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign diff   = r_diff;
    assign borrow = r_borrow;
    assign ovf    = r_ovf;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
